// File: rtl/m_dm_stage.sv
// ---------------------------------------------------------------------------
// m_dm_stage : memory-stage data-memory unit of the 5-stage MIPS pipeline.
//
// Executes lw/lh/lhu/lb/lbu/sw/sh/sb against an internal word-addressed
// memory of DEPTH words. Each memory instruction takes LAT extra wait cycles
// (LAT=0 gives single-cycle access). While the access is in flight M_busy is
// raised so the hazard unit freezes F/D/E/M, and the M->W register is loaded
// with a bubble. The access (store write / load sample) commits exactly once,
// on the last cycle of the instruction.
//
// Parameters:
//   DEPTH : number of 32-bit words in the data memory
//   LAT   : extra wait cycles per memory instruction, 0..15
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   M_Instr      M-stage instruction (32'b0 is a bubble)
//   M_PC         M-stage PC
//   M_check      M-stage register-write check flag
//   M_ALUResult  effective byte address (loads/stores) or pass-through value
//   M_WD2        store data
//   M_busy       hold request for upstream stages (combinational)
//   W_Instr, W_PC, W_check, W_ALUResult  registered M->W fields
//   W_DMRD       registered, extended load data (0 for non-loads)
//
// Optional feature macro: DM_STORE_TRACE_EN
//   When defined, every committed, non-suppressed store prints
//   "<time>@<pc>: *<word address> <= <resulting word>".
// ---------------------------------------------------------------------------
module m_dm_stage #(
  parameter int DEPTH = 3072,
  parameter int LAT   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_Instr,
  input  logic [31:0] M_PC,
  input  logic        M_check,
  input  logic [31:0] M_ALUResult,
  input  logic [31:0] M_WD2,
  output logic        M_busy,
  output logic [31:0] W_Instr,
  output logic [31:0] W_PC,
  output logic        W_check,
  output logic [31:0] W_ALUResult,
  output logic [31:0] W_DMRD
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic        HAS_WAIT = (LAT > 0) ? 1'b1 : 1'b0;
  localparam logic [3:0]  LAT_M1   = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] w_instr_q, w_instr_d;
  logic [31:0] w_pc_q, w_pc_d;
  logic        w_check_q, w_check_d;
  logic [31:0] w_alu_q, w_alu_d;
  logic [31:0] w_dmrd_q, w_dmrd_d;

  logic [5:0]       opcode_s;
  logic             is_load_s, is_store_s, is_mem_s, sext_s;
  logic [1:0]       size_s;
  logic [29:0]      word_idx_s;
  logic [1:0]       off_s;
  logic [IDX_W-1:0] mem_idx_s;
  logic             in_range_s, aligned_s, access_ok_s;
  logic [31:0]      mem_rd_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [31:0]      load_val_s;
  logic [31:0]      wr_word_s;
  logic             busy_s, commit_s, store_en_s;

  assign opcode_s   = M_Instr[31:26];
  assign is_mem_s   = is_load_s | is_store_s;
  assign word_idx_s = M_ALUResult[31:2];
  assign off_s      = M_ALUResult[1:0];
  assign mem_idx_s  = word_idx_s[IDX_W-1:0];
  assign in_range_s = ({2'b00, word_idx_s} < DEPTH_W);
  assign access_ok_s = in_range_s & aligned_s;
  assign store_en_s = commit_s & is_store_s & access_ok_s;

  // Opcode decode into load/store kind, access size and extension mode.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    size_s     = SZ_B;
    sext_s     = 1'b0;
    case (opcode_s)
      6'b100011: begin is_load_s  = 1'b1; size_s = SZ_W; end
      6'b100001: begin is_load_s  = 1'b1; size_s = SZ_H; sext_s = 1'b1; end
      6'b100101: begin is_load_s  = 1'b1; size_s = SZ_H; end
      6'b100000: begin is_load_s  = 1'b1; size_s = SZ_B; sext_s = 1'b1; end
      6'b100100: begin is_load_s  = 1'b1; size_s = SZ_B; end
      6'b101011: begin is_store_s = 1'b1; size_s = SZ_W; end
      6'b101001: begin is_store_s = 1'b1; size_s = SZ_H; end
      6'b101000: begin is_store_s = 1'b1; size_s = SZ_B; end
      default: begin end
    endcase
  end

  // Alignment rule for the decoded access size.
  always_comb begin
    aligned_s = 1'b1;
    case (size_s)
      SZ_W:    aligned_s = (off_s == 2'b00);
      SZ_H:    aligned_s = (off_s[0] == 1'b0);
      default: aligned_s = 1'b1;
    endcase
  end

  // Raw word read; an out-of-range index must not reach the array.
  always_comb begin
    if (in_range_s) begin
      mem_rd_s = mem_q[mem_idx_s];
    end else begin
      mem_rd_s = 32'd0;
    end
  end

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    byte_s = mem_rd_s[7:0];
    case (off_s)
      2'd0:    byte_s = mem_rd_s[7:0];
      2'd1:    byte_s = mem_rd_s[15:8];
      2'd2:    byte_s = mem_rd_s[23:16];
      2'd3:    byte_s = mem_rd_s[31:24];
      default: byte_s = mem_rd_s[7:0];
    endcase
    if (off_s[1]) begin
      half_s = mem_rd_s[31:16];
    end else begin
      half_s = mem_rd_s[15:0];
    end
    case (size_s)
      SZ_W:    load_val_s = mem_rd_s;
      SZ_H:    load_val_s = sext_s ? {{16{half_s[15]}}, half_s} : {16'd0, half_s};
      default: load_val_s = sext_s ? {{24{byte_s[7]}}, byte_s} : {24'd0, byte_s};
    endcase
  end

  // Merge store data into the current word; untouched lanes keep old data.
  always_comb begin
    wr_word_s = mem_rd_s;
    case (size_s)
      SZ_W: wr_word_s = M_WD2;
      SZ_H: begin
        if (off_s[1]) begin
          wr_word_s[31:16] = M_WD2[15:0];
        end else begin
          wr_word_s[15:0] = M_WD2[15:0];
        end
      end
      default: begin
        case (off_s)
          2'd0:    wr_word_s[7:0]   = M_WD2[7:0];
          2'd1:    wr_word_s[15:8]  = M_WD2[7:0];
          2'd2:    wr_word_s[23:16] = M_WD2[7:0];
          2'd3:    wr_word_s[31:24] = M_WD2[7:0];
          default: wr_word_s[7:0]   = M_WD2[7:0];
        endcase
      end
    endcase
  end

  // Wait-state FSM: decides when to hold upstream and when to commit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_s   = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem_s && HAS_WAIT) begin
          busy_s  = 1'b1;
          state_d = S_WAIT;
          cnt_d   = LAT_M1;
        end else begin
          commit_s = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          busy_s = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          commit_s = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Next M->W contents: the M fields on commit, a bubble while waiting.
  always_comb begin
    if (commit_s) begin
      w_instr_d = M_Instr;
      w_pc_d    = M_PC;
      w_check_d = M_check;
      w_alu_d   = M_ALUResult;
      w_dmrd_d  = (is_load_s && access_ok_s) ? load_val_s : 32'd0;
    end else begin
      w_instr_d = 32'd0;
      w_pc_d    = PC_RESET;
      w_check_d = 1'b0;
      w_alu_d   = 32'd0;
      w_dmrd_d  = 32'd0;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // M->W pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_instr_q <= 32'd0;
      w_pc_q    <= PC_RESET;
      w_check_q <= 1'b0;
      w_alu_q   <= 32'd0;
      w_dmrd_q  <= 32'd0;
    end else begin
      w_instr_q <= w_instr_d;
      w_pc_q    <= w_pc_d;
      w_check_q <= w_check_d;
      w_alu_q   <= w_alu_d;
      w_dmrd_q  <= w_dmrd_d;
    end
  end

  // Data array: cleared on reset, written once at the commit edge of a store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      if (store_en_s) begin
        mem_q[mem_idx_s] <= wr_word_s;
      end
    end
  end

`ifdef DM_STORE_TRACE_EN
  // Report every store that actually lands in the array.
  always_ff @(posedge clk) begin
    if (reset && store_en_s) begin
      $display("%d@%h: *%h <= %h", $time, M_PC, {M_ALUResult[31:2], 2'b00}, wr_word_s);
    end
  end
`else
  // Store tracing is not compiled into this build.
`endif

  // Hold is suppressed while reset is asserted.
  assign M_busy      = busy_s & reset;
  assign W_Instr     = w_instr_q;
  assign W_PC        = w_pc_q;
  assign W_check     = w_check_q;
  assign W_ALUResult = w_alu_q;
  assign W_DMRD      = w_dmrd_q;

endmodule

// File: tb/tb_m_dm_stage.sv
// Bench for m_dm_stage: three instances (LAT 0, 2, 3) run concurrent
// stimulus streams; a behavioural model predicts every output each cycle.
module tb_m_dm_stage;

  localparam int DEP = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] instr [3];
  logic [31:0] pc    [3];
  logic        check [3];
  logic [31:0] alu   [3];
  logic [31:0] wd2   [3];
  logic        busy    [3];
  logic [31:0] w_instr [3];
  logic [31:0] w_pc    [3];
  logic        w_check [3];
  logic [31:0] w_alu   [3];
  logic [31:0] w_dmrd  [3];

  m_dm_stage #(.DEPTH(DEP), .LAT(0)) u_lat0 (
    .clk(clk), .reset(reset), .M_Instr(instr[0]), .M_PC(pc[0]), .M_check(check[0]),
    .M_ALUResult(alu[0]), .M_WD2(wd2[0]), .M_busy(busy[0]), .W_Instr(w_instr[0]),
    .W_PC(w_pc[0]), .W_check(w_check[0]), .W_ALUResult(w_alu[0]), .W_DMRD(w_dmrd[0]));
  m_dm_stage #(.DEPTH(DEP), .LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .M_Instr(instr[1]), .M_PC(pc[1]), .M_check(check[1]),
    .M_ALUResult(alu[1]), .M_WD2(wd2[1]), .M_busy(busy[1]), .W_Instr(w_instr[1]),
    .W_PC(w_pc[1]), .W_check(w_check[1]), .W_ALUResult(w_alu[1]), .W_DMRD(w_dmrd[1]));
  m_dm_stage #(.DEPTH(DEP), .LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .M_Instr(instr[2]), .M_PC(pc[2]), .M_check(check[2]),
    .M_ALUResult(alu[2]), .M_WD2(wd2[2]), .M_busy(busy[2]), .W_Instr(w_instr[2]),
    .W_PC(w_pc[2]), .W_check(w_check[2]), .W_ALUResult(w_alu[2]), .W_DMRD(w_dmrd[2]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  localparam logic [5:0] OP_LW = 6'b100011, OP_LH = 6'b100001, OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB = 6'b100000, OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW = 6'b101011, OP_SH = 6'b101001, OP_SB = 6'b101000;

  function automatic bit is_load(logic [31:0] i);
    return i[31:26] inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
  endfunction
  function automatic bit is_store(logic [31:0] i);
    return i[31:26] inside {OP_SW, OP_SH, OP_SB};
  endfunction
  function automatic logic [31:0] mk(logic [5:0] op);
    logic [25:0] lo;
    lo = 26'($urandom);
    return {op, lo};
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mm [3][DEP];
  int          held [3];
  logic [31:0] e_instr [3], e_pc [3], e_alu [3], e_dmrd [3];
  logic        e_check [3];

  function automatic logic [31:0] model_load(int k, logic [31:0] i, logic [31:0] a);
    logic [31:0] widx, w, h, b;
    int off;
    widx = a >> 2;
    off  = int'(a % 4);
    if (widx >= DEP) return 32'd0;
    w = mm[k][widx];
    case (i[31:26])
      OP_LW: return (off == 0) ? w : 32'd0;
      OP_LH, OP_LHU: begin
        if (off % 2 != 0) return 32'd0;
        h = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
        if (i[31:26] == OP_LH && h >= 32'h0000_8000) return h | 32'hFFFF_0000;
        return h;
      end
      default: begin
        b = (w >> (8 * off)) & 32'h0000_00FF;
        if (i[31:26] == OP_LB && b >= 32'h0000_0080) return b | 32'hFFFF_FF00;
        return b;
      end
    endcase
  endfunction

  function automatic void model_store(int k, logic [31:0] i, logic [31:0] a, logic [31:0] d);
    logic [31:0] widx, mask;
    int off, sh;
    widx = a >> 2;
    off  = int'(a % 4);
    if (widx >= DEP) return;
    case (i[31:26])
      OP_SW: if (off == 0) mm[k][widx] = d;
      OP_SH: if (off % 2 == 0) begin
        sh = 16 * (off / 2);
        mask = 32'h0000_FFFF << sh;
        mm[k][widx] = (mm[k][widx] & ~mask) | ((d & 32'h0000_FFFF) << sh);
      end
      default: begin
        sh = 8 * off;
        mask = 32'h0000_00FF << sh;
        mm[k][widx] = (mm[k][widx] & ~mask) | ((d & 32'h0000_00FF) << sh);
      end
    endcase
  endfunction

  // Model state advance: an op sits in M for LAT+1 cycles, then commits.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        held[k] = 0;
        e_instr[k] = 32'd0; e_pc[k] = 32'h0000_3000; e_check[k] = 1'b0;
        e_alu[k] = 32'd0; e_dmrd[k] = 32'd0;
        for (int w = 0; w < DEP; w++) mm[k][w] = 32'd0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if ((is_load(instr[k]) || is_store(instr[k])) && held[k] < lat_of(k)) begin
          held[k]++;
          e_instr[k] = 32'd0; e_pc[k] = 32'h0000_3000; e_check[k] = 1'b0;
          e_alu[k] = 32'd0; e_dmrd[k] = 32'd0;
        end else begin
          held[k] = 0;
          e_instr[k] = instr[k]; e_pc[k] = pc[k]; e_check[k] = check[k];
          e_alu[k] = alu[k];
          e_dmrd[k] = is_load(instr[k]) ? model_load(k, instr[k], alu[k]) : 32'd0;
          if (is_store(instr[k])) model_store(k, instr[k], alu[k], wd2[k]);
        end
      end
    end
  end

  // Compare every output of every instance on each falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic eb;
      eb = reset && (is_load(instr[k]) || is_store(instr[k])) && held[k] < lat_of(k);
      chk($sformatf("k%0d_busy", k), {31'd0, busy[k]}, {31'd0, eb});
      chk($sformatf("k%0d_w_instr", k), w_instr[k], e_instr[k]);
      chk($sformatf("k%0d_w_pc", k), w_pc[k], e_pc[k]);
      chk($sformatf("k%0d_w_check", k), {31'd0, w_check[k]}, {31'd0, e_check[k]});
      chk($sformatf("k%0d_w_alu", k), w_alu[k], e_alu[k]);
      chk($sformatf("k%0d_w_dmrd", k), w_dmrd[k], e_dmrd[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(int k, logic [31:0] i, logic [31:0] a, logic [31:0] d);
    int n;
    instr[k] = i; pc[k] = $urandom; check[k] = 1'($urandom); alu[k] = a; wd2[k] = d;
    n = (is_load(i) || is_store(i)) ? lat_of(k) + 1 : 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_op(int k);
    logic [5:0] ops [8];
    logic [31:0] i, a;
    int sel;
    ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB};
    sel = $urandom_range(0, 11);
    if (sel < 8) i = mk(ops[sel]);
    else if (sel < 10) i = mk(6'b001000);
    else if (sel == 10) i = {6'b000000, 26'($urandom_range(1, 1000))};
    else i = 32'd0;
    sel = $urandom_range(0, 15);
    if (sel == 0) a = 32'(4 * DEP) + 32'($urandom_range(0, 63));
    else if (sel == 1) a = $urandom;
    else if (sel < 8) a = 32'($urandom_range(0, 15)) << 2;
    else a = 32'($urandom_range(0, 4 * DEP - 1));
    issue(k, i, a, $urandom);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      instr[k] = 32'd0; pc[k] = 32'd0; check[k] = 1'b0; alu[k] = 32'd0; wd2[k] = 32'd0;
    end
    #1 reset = 1'b0;
    #2;
    chk("rst_w_pc", w_pc[0], 32'h0000_3000);
    chk("rst_w_instr", w_instr[1], 32'd0);
    chk("rst_busy", {31'd0, busy[2]}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    fork
      begin : s0
        issue(0, mk(OP_SW), 32'h8, 32'h1234_5678);
        issue(0, mk(OP_LW), 32'h8, 32'hFFFF_FFFF);
        chk("lw_0x8", w_dmrd[0], 32'h1234_5678);
        issue(0, mk(OP_SW), 32'h0, 32'h1234_5678);
        issue(0, mk(OP_SB), 32'h1, 32'hFFFF_FFAB);
        chk("sb_word0", u_lat0.mem_q[0], 32'h1234_AB78);
        issue(0, mk(OP_LB), 32'h1, 32'd0);
        chk("lb_0x1", w_dmrd[0], 32'hFFFF_FFAB);
        issue(0, mk(OP_LBU), 32'h1, 32'd0);
        chk("lbu_0x1", w_dmrd[0], 32'h0000_00AB);
        issue(0, mk(OP_SW), 32'h4, 32'h8001_7FFF);
        issue(0, mk(OP_LH), 32'h6, 32'd0);
        chk("lh_0x6", w_dmrd[0], 32'hFFFF_8001);
        issue(0, mk(OP_LHU), 32'h6, 32'd0);
        chk("lhu_0x6", w_dmrd[0], 32'h0000_8001);
        issue(0, mk(OP_LH), 32'h4, 32'd0);
        chk("lh_0x4", w_dmrd[0], 32'h0000_7FFF);
        issue(0, mk(OP_SW), 32'h2, 32'hCAFE_F00D);
        issue(0, mk(OP_SW), 32'(4 * DEP), 32'h5555_5555);
        chk("mis_word0", u_lat0.mem_q[0], 32'h1234_AB78);
        chk("oor_word0", u_lat0.mem_q[0], 32'h1234_AB78);
        issue(0, mk(OP_LW), 32'h2, 32'd0);
        chk("lw_mis", w_dmrd[0], 32'd0);
        for (int n = 0; n < 400; n++) rand_op(0);
        instr[0] = 32'd0;
      end
      begin : s1
        instr[1] = mk(OP_SW); pc[1] = 32'h0000_3010; check[1] = 1'b0;
        alu[1] = 32'h10; wd2[1] = 32'hDEAD_BEEF;
        @(negedge clk) chk("l2_busy_c1", {31'd0, busy[1]}, 32'd1);
        @(posedge clk); #1;
        chk("l2_mem_e1", u_lat2.mem_q[4], 32'd0);
        chk("l2_bub_e1", w_instr[1], 32'd0);
        @(negedge clk) chk("l2_busy_c2", {31'd0, busy[1]}, 32'd1);
        @(posedge clk); #1;
        chk("l2_mem_e2", u_lat2.mem_q[4], 32'd0);
        @(negedge clk) chk("l2_busy_c3", {31'd0, busy[1]}, 32'd0);
        @(posedge clk); #1;
        chk("l2_mem_e3", u_lat2.mem_q[4], 32'hDEAD_BEEF);
        chk("l2_w_pc", w_pc[1], 32'h0000_3010);
        issue(1, mk(OP_LW), 32'h10, 32'd0);
        chk("l2_lw_0x10", w_dmrd[1], 32'hDEAD_BEEF);
        for (int n = 0; n < 200; n++) rand_op(1);
        instr[1] = 32'd0;
      end
      begin : s2
        for (int n = 0; n < 200; n++) rand_op(2);
        instr[2] = 32'd0;
      end
    join
    // Reset in the middle of a LAT=3 wait aborts the store.
    instr[0] = 32'd0; instr[1] = 32'd0;
    instr[2] = mk(OP_SW); alu[2] = 32'h20; wd2[2] = 32'h0BAD_F00D;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ra_busy", {31'd0, busy[2]}, 32'd0);
    chk("ra_w_instr", w_instr[2], 32'd0);
    chk("ra_w_pc", w_pc[2], 32'h0000_3000);
    chk("ra_w_dmrd", w_dmrd[2], 32'd0);
    instr[2] = 32'd0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    issue(2, mk(OP_LW), 32'h20, 32'd0);
    chk("ra_lw_0x20", w_dmrd[2], 32'd0);
    chk("ra_mem8", u_lat3.mem_q[8], 32'd0);
    instr[2] = 32'd0;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m_dm_stage.md
Name: m_dm_stage

Overview:
- Memory-stage data-memory unit of the 5-stage MIPS pipeline. Consumes the E→M pipeline register outputs (M_Instr, M_PC, M_check, M_ALUResult, M_WD2).
- Performs lw/lh/lhu/lb/lbu/sw/sh/sb against an internal word-addressed memory, with a configurable access latency.
- Drives the M→W pipeline register fields directly, and raises M_busy so the hazard unit stalls F/D/E/M while an access is in flight.

Parameters:
- DEPTH, 3072: number of 32-bit words in the data memory.
- LAT, 0: extra wait cycles per memory instruction. 0 means single-cycle access. Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- M_Instr  input  32  M-stage instruction; 32'b0 is a bubble
- M_PC  input  32  M-stage PC
- M_check  input  1  M-stage register-write check flag
- M_ALUResult  input  32  effective byte address for loads/stores; pass-through value otherwise
- M_WD2  input  32  store data (rt value, already forwarded)
- M_busy  output  1  high while the current M instruction must be held; upstream stages freeze
- W_Instr  output  32  registered instruction for W
- W_PC  output  32  registered PC for W
- W_check  output  1  registered check flag
- W_ALUResult  output  32  registered ALU result
- W_DMRD  output  32  registered, extended load data (0 for non-loads)

Behaviour:
- Decode uses opcode M_Instr[31:26]:
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100
  - sw 101011, sh 101001, sb 101000
  - Anything else is a non-memory op.
- Addressing: word index = M_ALUResult[31:2]; byte offset = M_ALUResult[1:0].
- Out of range (index ≥ DEPTH): store suppressed, load returns 0.
- Misaligned lw/sw (offset≠0) and lh/lhu/sh (offset[0]=1): store suppressed, load returns 0. No exception is raised.
- Stores:
  - sw writes the full word.
  - sh writes the halfword at offset[1] (0 = bits 15:0, 1 = bits 31:16) from M_WD2[15:0].
  - sb writes byte lane offset (lane 0 = bits 7:0) from M_WD2[7:0].
  - Other bytes of the word are unchanged.
- Loads:
  - lb/lh sign-extend the selected lane.
  - lbu/lhu zero-extend it.
  - lw returns the word.
- FSM states IDLE, WAIT:
  - IDLE, memory op, LAT>0: M_busy=1 combinationally; next state WAIT; cnt<=LAT-1; W_* load a bubble (all zero, W_PC=0x00003000).
  - WAIT, cnt≠0: M_busy=1; cnt<=cnt-1; W_* load a bubble.
  - WAIT, cnt=0: M_busy=0; commit the access at this edge; W_* capture the M inputs plus load data; next state IDLE.
  - IDLE, non-memory op or LAT=0: M_busy=0; commit/capture at this edge.
- Timing: a memory op occupies LAT+1 cycles. A store writes the array exactly once, at the commit edge. Load data is sampled from the array at the commit edge.
- Inputs are held stable by upstream while M_busy=1. Changes in M inputs during WAIT are ignored until commit.
- Back-to-back memory ops: the second enters IDLE on the cycle after the first commits and starts its own wait.
- A bubble (M_Instr=0) never asserts M_busy.
- Reset (async, reset=0):
  - state=IDLE, cnt=0, M_busy=0.
  - W_Instr=0, W_PC=0x00003000, W_check=0, W_ALUResult=0, W_DMRD=0.
  - All memory words cleared to 0.
  - Reset during WAIT aborts the access; no memory write occurs.

Optional Feature:
- DM_STORE_TRACE_EN defined: at each committed, non-suppressed store, print "%d@%h: *%h <= %h" with $time, M_PC, the word-aligned address, and the full resulting word.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

Test Plan:
- LAT=0. sw, addr 0x8, WD2=0x12345678; then lw 0x8 → M_busy never high; next-cycle W_DMRD=0x12345678.
- LAT=0. Word 0 holds 0x12345678; sb 0x1 with WD2=0xFFFFFFAB → word 0 = 0x1234AB78. lb 0x1 → W_DMRD=0xFFFFFFAB; lbu 0x1 → 0x000000AB.
- LAT=0. Word 1 holds 0x8001_7FFF; lh 0x6 → 0xFFFF8001; lhu 0x6 → 0x00008001; lh 0x4 → 0x00007FFF.
- LAT=2. sw addr 0x10, 0xDEADBEEF:
  - M_busy high for 2 cycles, low on the 3rd.
  - W_* are bubbles for 2 cycles.
  - Memory is written only at the 3rd edge.
  - A following lw 0x10 returns 0xDEADBEEF.
- LAT=0. Misaligned sw 0x2 and out-of-range sw at 4*DEPTH → memory unchanged; lw 0x2 → W_DMRD=0.
- LAT=3. sw issued, reset pulled low mid-WAIT → outputs at reset values immediately; the target word stays 0 after reset is released.
